inst_fetch_ctrl: RTL

- Fetch-side controller on the far side of the ibuffer fetch handshake.
- Owns the fetch PC and answers the ibuffer's fetch_inst requests by issuing 64-bit reads (two 32-bit instructions) to the instruction-memory arbiter.
- Delivers each returned word to the ibuffer with a one-cycle pc_operation_done pulse, plus pc_read_inst and pc.
- Handles pipeline redirects: it discards any in-flight response and pulses clear_ibuffer.

---
 rtl/inst_fetch_ctrl_pkg.sv | 17 +
 rtl/inst_fetch_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared frontend definitions for the instruction-fetch controller.
package inst_fetch_ctrl_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned FETCH_W = 64;

  localparam logic [63:0] DEFAULT_RESET_PC    = 64'h0000_0000_8000_0000;
  localparam int unsigned DEFAULT_FETCH_BYTES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetch PC owner: issues 64-bit imem reads on ibuffer request and hands the data back.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned FETCH_BYTES = DEFAULT_FETCH_BYTES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_inst,
  input  logic               mem_stall,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_target,
  output logic               imem_req_valid,
  output logic [63:0]        imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [FETCH_W-1:0] imem_resp_data,
  output logic               pc_operation_done,
  output logic [FETCH_W-1:0] pc_read_inst,
  output logic [63:0]        pc,
  output logic               can_fetch_inst,
  output logic               clear_ibuffer
);

  fetch_state_e       r_state, w_state_d;
  logic [63:0]        r_fetch_pc, w_fetch_pc_d;
  logic               r_kick, w_kick_d;
  logic               r_done, w_done_d;
  logic               r_clear, w_clear_d;
  logic [63:0]        r_pc, w_pc_d;
  logic [FETCH_W-1:0] r_inst, w_inst_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_kick     <= 1'b1;
      r_done     <= 1'b0;
      r_clear    <= 1'b0;
      r_pc       <= RESET_PC;
      r_inst     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_kick     <= w_kick_d;
      r_done     <= w_done_d;
      r_clear    <= w_clear_d;
      r_pc       <= w_pc_d;
      r_inst     <= w_inst_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    w_kick_d     = r_kick;
    w_done_d     = 1'b0;
    w_clear_d    = redirect_valid;
    w_pc_d       = r_pc;
    w_inst_d     = r_inst;

    if (redirect_valid) begin
      w_fetch_pc_d = redirect_target & ~64'h3;
      w_kick_d     = 1'b1;
      // An accepted request still owes a response, which must be swallowed.
      unique case (r_state)
        StIdle:  w_state_d = StIdle;
        StReq:   w_state_d = imem_req_ready ? StDrop : StIdle;
        StWait:  w_state_d = imem_resp_valid ? StIdle : StDrop;
        StDrop:  w_state_d = imem_resp_valid ? StIdle : StDrop;
        default: w_state_d = StIdle;
      endcase
    end else begin
      unique case (r_state)
        StIdle: begin
          if ((r_kick || fetch_inst) && !mem_stall) begin
            w_state_d = StReq;
            w_kick_d  = 1'b0;
          end
        end
        StReq: begin
          if (imem_req_ready) w_state_d = StWait;
        end
        StWait: begin
          if (imem_resp_valid) begin
            w_done_d     = 1'b1;
            w_pc_d       = r_fetch_pc;
            w_inst_d     = imem_resp_data;
            w_fetch_pc_d = r_fetch_pc + 64'(FETCH_BYTES);
            w_state_d    = StIdle;
          end
        end
        StDrop: begin
          if (imem_resp_valid) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign imem_req_valid    = (r_state == StReq);
  assign imem_req_addr     = r_fetch_pc;
  assign pc_operation_done = r_done;
  assign pc_read_inst      = r_inst;
  assign pc                = r_pc;
  assign can_fetch_inst    = (r_state == StIdle) && !r_kick;
  assign clear_ibuffer     = r_clear;

endmodule
